// File: rtl/vram_pkg.sv
// Shared types for the VRAM port arbiter: default widths, grant states,
// buffered write record and the grant priority function.
package vram_pkg;

  localparam int VRAM_ADDR_W = 19;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } arb_state_t;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_wr_t;

  // Scan-out always wins; buffered writes only use idle RAM cycles.
  function automatic arb_state_t arb_grant(
    input logic scan,
    input logic pend
  );
    arb_state_t g;
    g = IDLE;
    unique case (1'b1)
      scan:        g = READ;
      (!scan && pend): g = WRITE;
      default:     g = IDLE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-buffer FIFO for the VRAM arbiter.
// Ports: clk, rst (async high), push/push_data, pop, head, full, empty.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter type T     = vram_wr_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  // full/empty come from the registered count, so a same-cycle pop
  // never makes room for a push.
  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM sharer: scan-out reads win, writes buffered and drained
// into idle cycles. Ports: Clk, Reset, scan_*, wr_*, ram_*, stall_cnt.
// Optional macro VRAM_ARB_STALL_STATS_EN enables the stall_cnt counter.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  arb_state_t state;
  arb_state_t grant;
  wr_t        head;
  wr_t        in_wr;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  assign in_wr    = '{addr: wr_addr, data: wr_data};
  assign wr_ready = !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign grant    = arb_grant(scan_req, !fifo_empty);
  assign pop      = (grant == WRITE);

  vram_wr_fifo #(
    .T     (wr_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .push      (push),
    .push_data (in_wr),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // state is the grant of the previous cycle; READ in state means the
  // RAM is strobed now and returns data next cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      scan_valid <= 1'b0;
    end else begin
      state      <= grant;
      scan_valid <= (state == READ);
      unique case (grant)
        READ: begin
          ram_en   <= 1'b1;
          ram_we   <= 1'b0;
          ram_addr <= scan_addr;
        end
        WRITE: begin
          ram_en    <= 1'b1;
          ram_we    <= 1'b1;
          ram_addr  <= head.addr;
          ram_wdata <= head.data;
        end
        default: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign scan_data = scan_valid ? ram_rdata : '0;

`ifdef VRAM_ARB_STALL_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_q <= '0;
    end else if (scan_req && !fifo_empty && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Testbench for vram_port_arbiter: queue-based model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_vram_port_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          scan_req = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic [DW-1:0] scan_data;
  logic          scan_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [15:0]   stall_cnt;

  int nvec = 0;
  int nerr = 0;
  int sv_count = 0;
  int we_count = 0;
  int hs_count = 0;
  int hs0;

  always #5 Clk = ~Clk;

  vram_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .scan_req   (scan_req),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .stall_cnt  (stall_cnt)
  );

  function automatic logic [DW-1:0] base(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Synchronous VRAM attached to the DUT.
  logic [DW-1:0] ram_mem [int];

  always @(posedge Clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= ram_mem.exists(int'(ram_addr)) ?
                        ram_mem[int'(ram_addr)] : base(ram_addr);
    end
  end

  // Reference model: a queue for the buffer and a memory image updated
  // in grant order, since the RAM performs exactly one op per grant.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  wr_t           m_w;
  logic [DW-1:0] mm [int];
  logic          m_en = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          v1 = 1'b0;
  logic          v2 = 1'b0;
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] d2 = '0;
  int            m_stall = 0;
  bit            m_acc;

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : base(a);
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q.delete();
      m_en = 1'b0;
      m_we = 1'b0;
      m_addr = '0;
      m_wdata = '0;
      v1 = 1'b0;
      v2 = 1'b0;
      m_stall = 0;
    end else begin
      m_acc = wr_valid && (q.size() < DEPTH);
      if (m_acc) hs_count++;
      v2 = v1;
      d2 = d1;
      v1 = scan_req;
      d1 = scan_req ? model_rd(scan_addr) : '0;
      if (scan_req) begin
        m_en = 1'b1;
        m_we = 1'b0;
        m_addr = scan_addr;
`ifdef VRAM_ARB_STALL_STATS_EN
        if (q.size() > 0 && m_stall < 65535) m_stall++;
`endif
      end else if (q.size() > 0) begin
        m_w = q.pop_front();
        mm[int'(m_w.a)] = m_w.d;
        m_en = 1'b1;
        m_we = 1'b1;
        m_addr = m_w.a;
        m_wdata = m_w.d;
      end else begin
        m_en = 1'b0;
        m_we = 1'b0;
      end
      if (m_acc) q.push_back('{wr_addr, wr_data});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    chk("ram_en", 32'(ram_en), 32'(m_en));
    chk("ram_we", 32'(ram_we), 32'(m_we));
    chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    chk("scan_valid", 32'(scan_valid), 32'(v2));
    if (v2) chk("scan_data", 32'(scan_data), 32'(d2));
    chk("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (scan_valid) sv_count++;
    if (ram_en && ram_we) we_count++;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    acc = 1'b0;
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    chk("push_timeout", 32'(acc), 32'd1);
  endtask

  initial begin
    #1 Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    tick();

    // single write, no scan traffic
    wr_valid = 1'b1;
    wr_addr = 19'h00010;
    wr_data = 8'hA5;
    tick();
    wr_valid = 1'b0;
    tick();
    @(negedge Clk);
    chk("t1_we", 32'(ram_we), 32'd1);
    chk("t1_addr", 32'(ram_addr), 32'h10);
    chk("t1_wdata", 32'(ram_wdata), 32'hA5);
    tick();
    @(negedge Clk);
    chk("t1_idle", 32'(ram_en), 32'd0);
    chk("t1_ready", 32'(wr_ready), 32'd1);
    tick();

    // continuous scan of 8 addresses
    sv_count = 0;
    we_count = 0;
    for (int i = 0; i < 8; i++) begin
      scan_req = 1'b1;
      scan_addr = AW'(i);
      if (i == 2) begin
        @(negedge Clk);
        chk("t2_first_valid", 32'(scan_valid), 32'd1);
        chk("t2_first_data", 32'(scan_data), 32'h5A);
      end
      tick();
    end
    scan_req = 1'b0;
    repeat (3) tick();
    chk("t2_valid_count", 32'(sv_count), 32'd8);
    chk("t2_no_writes", 32'(we_count), 32'd0);

    // fill the buffer under constant scan, then drain
    scan_req = 1'b1;
    scan_addr = 19'h00100;
    for (int k = 0; k < 4; k++) push(AW'(19'h300 + k), DW'(8'h30 + k));
    wr_valid = 1'b1;
    wr_addr = 19'h00304;
    wr_data = 8'h34;
    @(negedge Clk);
    chk("t3_full", 32'(wr_ready), 32'd0);
`ifdef VRAM_ARB_STALL_STATS_EN
    chk("t3_stall3", 32'(stall_cnt), 32'd3);
`endif
    tick();
    tick();
    scan_req = 1'b0;
    tick();
    @(negedge Clk);
    chk("t3_drain_we", 32'(ram_we), 32'd1);
    chk("t3_drain_addr", 32'(ram_addr), 32'h300);
    chk("t3_ready_again", 32'(wr_ready), 32'd1);
`ifdef VRAM_ARB_STALL_STATS_EN
    chk("t3_stall5", 32'(stall_cnt), 32'd5);
`endif
    tick();
    wr_valid = 1'b0;
    repeat (6) tick();
    chk("t3_fifth_in_ram", 32'(ram_mem[32'h304]), 32'h34);
    chk("t3_drained", 32'(ram_en), 32'd0);

    // alternating scan with continuous write offers
    sv_count = 0;
    we_count = 0;
    hs0 = hs_count;
    for (int i = 0; i < 20; i++) begin
      scan_req = (i % 2 == 0);
      scan_addr = AW'(19'h300 + (i % 5));
      wr_valid = 1'b1;
      wr_addr = AW'(19'h400 + i);
      wr_data = DW'(8'h80 + i);
      tick();
    end
    scan_req = 1'b0;
    wr_valid = 1'b0;
    repeat (8) tick();
    chk("t4_reads", 32'(sv_count), 32'd10);
    chk("t4_accepted", 32'(hs_count - hs0), 32'd13);
    chk("t4_retired", 32'(we_count), 32'd13);

    // reset with buffered writes and reads in flight
    scan_req = 1'b1;
    scan_addr = 19'h00010;
    for (int k = 0; k < 3; k++) push(AW'(19'h500 + k), DW'(8'h50 + k));
    #1 Reset = 1'b1;
    scan_req = 1'b0;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk);
    chk("t5_ready", 32'(wr_ready), 32'd1);
    chk("t5_stall", 32'(stall_cnt), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("t5_no_en", 32'(ram_en), 32'd0);
      chk("t5_no_valid", 32'(scan_valid), 32'd0);
      @(negedge Clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
